// File: rtl/ddr_test_pkg.sv
// Shared constants for the DDR3 pattern checker: the 64-bit lane pattern table,
// the controller state encoding, the start-mode encodings and the app_cmd opcodes.
package ddr_test_pkg;

  // A beat is built from 64-bit lanes. Lane k of beat i uses entry (i+k) mod 8.
  localparam logic [63:0] PATTERN [0:7] = '{
    64'h5883adb4c88ad596,
    64'h1122334455667788,
    64'h99aabbccddeeff00,
    64'h0000ffff0000ffff,
    64'hffff0000ffff0000,
    64'h00000000ffff0000,
    64'haf5d632fc8b91658,
    64'hffffffff0000ffff
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DONE
  } state_e;

  // Mode 3 behaves exactly like mode 0.
  typedef enum logic [1:0] {
    MODE_WR_RD     = 2'd0,
    MODE_WR_ONLY   = 2'd1,
    MODE_RD_ONLY   = 2'd2,
    MODE_WR_RD_ALT = 2'd3
  } mode_e;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

endpackage

// File: rtl/ddr_pattern_gen.sv
// Combinational beat pattern generator. The pattern repeats every 8 beats, so
// only the beat index modulo 8 (beat_phase) is needed to build a full beat.
module ddr_pattern_gen
  import ddr_test_pkg::*;
#(
  parameter int APP_DATA_WIDTH = 256
) (
  input  logic [2:0]                beat_phase,
  output logic [APP_DATA_WIDTH-1:0] data
);

  localparam int LANES = APP_DATA_WIDTH / 64;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    localparam logic [2:0] LANE_OFS = 3'(k % 8);
    logic [2:0] sel;
    // The 3-bit add wraps naturally, giving (i + k) mod 8.
    assign sel = beat_phase + LANE_OFS;
    assign data[k*64 +: 64] = PATTERN[sel];
  end

endmodule

// File: rtl/ddr_pattern_checker.sv
// DDR3 memory-test traffic generator and checker on the MIG app_* interface.
// Writes a deterministic pattern over an address window, reads it back and
// counts mismatching beats, recording the address of the first one.
module ddr_pattern_checker
  import ddr_test_pkg::*;
#(
  parameter int ADDR_WIDTH     = 28,
  parameter int APP_DATA_WIDTH = 256,
  parameter int APP_MASK_WIDTH = 32,
  parameter int BASE_ADDR      = 0,
  parameter int ADDR_STEP      = 8,
  parameter int NUM_BEATS      = 64,
  parameter int TIMEOUT        = 4096
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      init_calib_complete,
  input  logic                      start,
  input  logic [1:0]                mode,
  input  logic                      app_rdy,
  input  logic                      app_wdf_rdy,
  input  logic                      app_rd_data_valid,
  input  logic [APP_DATA_WIDTH-1:0] app_rd_data,
  output logic                      app_en,
  output logic [2:0]                app_cmd,
  output logic [ADDR_WIDTH-1:0]     app_addr,
  output logic [APP_DATA_WIDTH-1:0] app_wdf_data,
  output logic                      app_wdf_wren,
  output logic                      app_wdf_end,
  output logic [APP_MASK_WIDTH-1:0] app_wdf_mask,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic                      timeout,
  output logic [15:0]               err_count,
  output logic [ADDR_WIDTH-1:0]     first_err_addr
);

  // Counters need to hold NUM_BEATS itself and at least 3 bits for the pattern phase.
  localparam int CNT_RAW = $clog2(NUM_BEATS + 1);
  localparam int CNT_W   = (CNT_RAW < 3) ? 3 : CNT_RAW;
  localparam int WD_W    = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0]      LAST_IDX = CNT_W'(NUM_BEATS - 1);
  localparam logic [CNT_W-1:0]      NUM_IDX  = CNT_W'(NUM_BEATS);
  localparam logic [WD_W-1:0]       WD_LAST  = WD_W'(TIMEOUT - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] STEP     = ADDR_WIDTH'(ADDR_STEP);

  state_e                    state_q, state_d;
  mode_e                     mode_q, mode_d;
  logic [CNT_W-1:0]          wr_idx_q, wr_idx_d;
  logic [CNT_W-1:0]          rd_cmd_idx_q, rd_cmd_idx_d;
  logic [CNT_W-1:0]          ret_idx_q, ret_idx_d;
  logic [ADDR_WIDTH-1:0]     ret_addr_q, ret_addr_d;
  logic [WD_W-1:0]           wdog_q, wdog_d;
  logic                      app_en_q, app_en_d;
  logic [2:0]                app_cmd_q, app_cmd_d;
  logic [ADDR_WIDTH-1:0]     app_addr_q, app_addr_d;
  logic [APP_DATA_WIDTH-1:0] wdf_data_q, wdf_data_d;
  logic                      wdf_wren_q, wdf_wren_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      pass_q, pass_d;
  logic                      timeout_q, timeout_d;
  logic [15:0]               err_count_q, err_count_d;
  logic [ADDR_WIDTH-1:0]     first_err_q, first_err_d;

  logic [2:0]                wr_phase;
  logic [APP_DATA_WIDTH-1:0] wr_data;
  logic [APP_DATA_WIDTH-1:0] exp_data;
  logic                      rd_mismatch;
  logic                      wr_cmd_ok;
  logic                      wr_dat_ok;

  // Write data is always loaded for the beat about to be presented: beat 0 on
  // entry, otherwise the beat after the one currently held.
  assign wr_phase = (state_q == ST_WRITE) ? (wr_idx_q[2:0] + 3'd1) : 3'd0;

  ddr_pattern_gen #(.APP_DATA_WIDTH(APP_DATA_WIDTH)) u_wr_gen (
    .beat_phase (wr_phase),
    .data       (wr_data)
  );

  ddr_pattern_gen #(.APP_DATA_WIDTH(APP_DATA_WIDTH)) u_exp_gen (
    .beat_phase (ret_idx_q[2:0]),
    .data       (exp_data)
  );

  assign rd_mismatch = (app_rd_data != exp_data);

  // A channel is finished with the current beat if it was already accepted
  // earlier (deasserted) or is being accepted this cycle.
  assign wr_cmd_ok = !app_en_q || app_rdy;
  assign wr_dat_ok = !wdf_wren_q || app_wdf_rdy;

  // Next-state and next-output logic for the test sequencer.
  always_comb begin
    // NOTE: every *_d gets its hold value first, so no branch can leave one
    // unassigned and infer a latch.
    state_d      = state_q;
    mode_d       = mode_q;
    wr_idx_d     = wr_idx_q;
    rd_cmd_idx_d = rd_cmd_idx_q;
    ret_idx_d    = ret_idx_q;
    ret_addr_d   = ret_addr_q;
    wdog_d       = wdog_q;
    app_en_d     = app_en_q;
    app_cmd_d    = app_cmd_q;
    app_addr_d   = app_addr_q;
    wdf_data_d   = wdf_data_q;
    wdf_wren_d   = wdf_wren_q;
    done_d       = done_q;
    pass_d       = pass_q;
    timeout_d    = timeout_q;
    err_count_d  = err_count_q;
    first_err_d  = first_err_q;
    busy_d       = busy_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start && init_calib_complete) begin
          mode_d       = mode_e'(mode);
          wr_idx_d     = '0;
          rd_cmd_idx_d = '0;
          ret_idx_d    = '0;
          ret_addr_d   = BASE;
          wdog_d       = '0;
          app_addr_d   = BASE;
          app_en_d     = 1'b1;
          done_d       = 1'b0;
          pass_d       = 1'b0;
          timeout_d    = 1'b0;
          err_count_d  = '0;
          first_err_d  = '0;
          if (mode_e'(mode) == MODE_RD_ONLY) begin
            state_d   = ST_READ;
            app_cmd_d = CMD_READ;
          end else begin
            state_d    = ST_WRITE;
            app_cmd_d  = CMD_WRITE;
            wdf_wren_d = 1'b1;
            wdf_data_d = wr_data;
          end
        end
      end

      ST_WRITE: begin
        if (app_en_q && app_rdy) app_en_d = 1'b0;
        if (wdf_wren_q && app_wdf_rdy) wdf_wren_d = 1'b0;
        if (wr_cmd_ok && wr_dat_ok) begin
          if (wr_idx_q == LAST_IDX) begin
            if (mode_q == MODE_WR_ONLY) begin
              state_d = ST_DONE;
            end else begin
              state_d      = ST_READ;
              app_en_d     = 1'b1;
              app_cmd_d    = CMD_READ;
              app_addr_d   = BASE;
              rd_cmd_idx_d = '0;
              ret_idx_d    = '0;
              ret_addr_d   = BASE;
              wdog_d       = '0;
            end
          end else begin
            wr_idx_d   = wr_idx_q + CNT_W'(1);
            app_en_d   = 1'b1;
            wdf_wren_d = 1'b1;
            app_addr_d = app_addr_q + STEP;
            wdf_data_d = wr_data;
          end
        end
      end

      ST_READ: begin
        // Command side: one read per accept until all beats are requested.
        if (app_en_q && app_rdy) begin
          if (rd_cmd_idx_q == LAST_IDX) begin
            app_en_d = 1'b0;
          end else begin
            rd_cmd_idx_d = rd_cmd_idx_q + CNT_W'(1);
            app_addr_d   = app_addr_q + STEP;
          end
        end
        // Return side: the last compare has landed once the counter hits NUM_BEATS.
        if (ret_idx_q == NUM_IDX) begin
          state_d  = ST_DONE;
          app_en_d = 1'b0;
        end else if (app_rd_data_valid) begin
          wdog_d     = '0;
          ret_idx_d  = ret_idx_q + CNT_W'(1);
          ret_addr_d = ret_addr_q + STEP;
          if (rd_mismatch) begin
            if (err_count_q == '0) first_err_d = ret_addr_q;
            if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
          end
        end else if (wdog_q == WD_LAST) begin
          timeout_d = 1'b1;
          state_d   = ST_DONE;
          app_en_d  = 1'b0;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Verdict is captured on the cycle the sequencer enters DONE.
    if (state_d == ST_DONE && state_q != ST_DONE) begin
      done_d = 1'b1;
      pass_d = (err_count_d == '0) && !timeout_d;
    end
    busy_d = (state_d == ST_WRITE) || (state_d == ST_READ);
  end

  // State and registered outputs; reset drops everything back to IDLE at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      mode_q       <= MODE_WR_RD;
      wr_idx_q     <= '0;
      rd_cmd_idx_q <= '0;
      ret_idx_q    <= '0;
      ret_addr_q   <= '0;
      wdog_q       <= '0;
      app_en_q     <= 1'b0;
      app_cmd_q    <= 3'b000;
      app_addr_q   <= '0;
      wdf_data_q   <= '0;
      wdf_wren_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      timeout_q    <= 1'b0;
      err_count_q  <= '0;
      first_err_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q      <= state_d;
      mode_q       <= mode_d;
      wr_idx_q     <= wr_idx_d;
      rd_cmd_idx_q <= rd_cmd_idx_d;
      ret_idx_q    <= ret_idx_d;
      ret_addr_q   <= ret_addr_d;
      wdog_q       <= wdog_d;
      app_en_q     <= app_en_d;
      app_cmd_q    <= app_cmd_d;
      app_addr_q   <= app_addr_d;
      wdf_data_q   <= wdf_data_d;
      wdf_wren_q   <= wdf_wren_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      timeout_q    <= timeout_d;
      err_count_q  <= err_count_d;
      first_err_q  <= first_err_d;
    end
  end

  assign app_en         = app_en_q;
  assign app_cmd        = app_cmd_q;
  assign app_addr       = app_addr_q;
  assign app_wdf_data   = wdf_data_q;
  assign app_wdf_wren   = wdf_wren_q;
  assign app_wdf_end    = wdf_wren_q;
  assign app_wdf_mask   = '0;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign timeout        = timeout_q;
  assign err_count      = err_count_q;
  assign first_err_addr = first_err_q;

endmodule

// File: tb/tb_ddr_pattern_checker.sv
// Bench for ddr_pattern_checker: a simple DDR3 IP model (accept bookkeeping,
// backing memory, fixed-latency read returns) plus table-driven runs and a few
// hand-written corner-case sequences.
module tb_ddr_pattern_checker;

  localparam int AW = 28;
  localparam int DW = 256;
  localparam int MW = 32;
  localparam int NB = 16;
  localparam int TO = 4096;
  localparam int RD_LAT = 3;

  localparam logic [63:0] PAT [0:7] = '{
    64'h5883adb4c88ad596, 64'h1122334455667788, 64'h99aabbccddeeff00, 64'h0000ffff0000ffff,
    64'hffff0000ffff0000, 64'h00000000ffff0000, 64'haf5d632fc8b91658, 64'hffffffff0000ffff
  };

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          init_calib_complete = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic          app_rdy = 1'b1;
  logic          app_wdf_rdy = 1'b1;
  logic          app_rd_data_valid = 1'b0;
  logic [DW-1:0] app_rd_data = '0;
  logic          app_en;
  logic [2:0]    app_cmd;
  logic [AW-1:0] app_addr;
  logic [DW-1:0] app_wdf_data;
  logic          app_wdf_wren;
  logic          app_wdf_end;
  logic [MW-1:0] app_wdf_mask;
  logic          busy;
  logic          done;
  logic          pass;
  logic          timeout;
  logic [15:0]   err_count;
  logic [AW-1:0] first_err_addr;

  ddr_pattern_checker #(
    .ADDR_WIDTH(AW), .APP_DATA_WIDTH(DW), .APP_MASK_WIDTH(MW),
    .BASE_ADDR(0), .ADDR_STEP(8), .NUM_BEATS(NB), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .init_calib_complete(init_calib_complete),
    .start(start), .mode(mode), .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data_valid(app_rd_data_valid), .app_rd_data(app_rd_data),
    .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr),
    .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren),
    .app_wdf_end(app_wdf_end), .app_wdf_mask(app_wdf_mask), .busy(busy),
    .done(done), .pass(pass), .timeout(timeout), .err_count(err_count),
    .first_err_addr(first_err_addr)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_data(input int beat);
    logic [DW-1:0] d;
    for (int k = 0; k < DW / 64; k++) d[k*64 +: 64] = PAT[(beat + k) % 8];
    return d;
  endfunction

  // ---------------- IP model ----------------
  typedef struct {
    logic [AW-1:0] addr;
    int            due;
  } rd_t;

  logic [DW-1:0] mem [64];
  logic [AW-1:0] wcmd_q [$];
  logic [DW-1:0] wdat_q [$];
  rd_t           rd_q [$];
  int cyc = 0;
  int wcmd_cnt, wdat_cnt, rcmd_cnt, rd_ret_cnt, model_bad, en_seen, last_valid_cyc;
  bit corrupt = 1'b0;
  bit no_return = 1'b0;

  task automatic clear_model();
    wcmd_q.delete();
    wdat_q.delete();
    rd_q.delete();
    wcmd_cnt = 0; wdat_cnt = 0; rcmd_cnt = 0; rd_ret_cnt = 0;
    model_bad = 0; en_seen = 0; last_valid_cyc = 0;
  endtask

  // Accept bookkeeping at the active edge: sees the pre-edge DUT outputs.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (!rst) begin
      if (app_en) en_seen++;
      if (app_en && app_rdy) begin
        if (app_cmd == 3'b000) begin
          if (app_addr != AW'(wcmd_cnt * 8)) model_bad++;
          wcmd_q.push_back(app_addr);
          wcmd_cnt++;
        end else if (app_cmd == 3'b001) begin
          if (app_addr != AW'(rcmd_cnt * 8)) model_bad++;
          rd_q.push_back('{addr: app_addr, due: cyc + RD_LAT});
          rcmd_cnt++;
        end else begin
          model_bad++;
        end
      end
      if (app_wdf_wren && app_wdf_rdy) begin
        if (app_wdf_data != exp_data(wdat_cnt)) model_bad++;
        wdat_q.push_back(app_wdf_data);
        wdat_cnt++;
      end
      if (app_wdf_end != app_wdf_wren || app_wdf_mask != '0) model_bad++;
      while (wcmd_q.size() > 0 && wdat_q.size() > 0) begin
        logic [AW-1:0] a;
        a = wcmd_q.pop_front();
        mem[int'(a[8:3])] = wdat_q.pop_front();
      end
    end
  end

  // Read-return driver on the inactive edge.
  initial forever begin
    @(negedge clk);
    if (!rst && !no_return && rd_q.size() > 0 && rd_q[0].due <= cyc) begin
      rd_t e;
      logic [DW-1:0] d;
      e = rd_q.pop_front();
      d = mem[int'(e.addr[8:3])];
      if (corrupt && (e.addr == AW'(24) || e.addr == AW'(72))) d[0] = ~d[0];
      app_rd_data = d;
      app_rd_data_valid = 1'b1;
      rd_ret_cnt++;
      last_valid_cyc = cyc;
    end else begin
      app_rd_data_valid = 1'b0;
    end
  end

  // ---------------- helpers ----------------
  task automatic start_run(input logic [1:0] m);
    @(negedge clk);
    mode = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int n);
    n = 0;
    while (done !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("done_reached", done, 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, {app_en, app_wdf_wren, app_wdf_end, busy, done, pass, timeout}, 0);
    check({tag, "_addr"}, app_addr, 0);
    check({tag, "_wdata"}, {63'd0, |app_wdf_data}, 0);
    check({tag, "_err"}, {err_count, first_err_addr}, 0);
  endtask

  typedef struct {
    logic [1:0]    mode;
    bit            corrupt;
    int            exp_wr;
    int            exp_rd;
    logic [15:0]   exp_err;
    logic [AW-1:0] exp_first;
    logic          exp_pass;
  } vec_t;

  vec_t vecs [5];

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit reached");
    $fatal(1, "bench time limit");
  end

  initial begin
    int n;
    logic [DW-1:0] held;
    bit found;

    vecs[0] = '{mode: 2'd0, corrupt: 1'b0, exp_wr: 16, exp_rd: 16, exp_err: 16'd0, exp_first: '0,     exp_pass: 1'b1};
    vecs[1] = '{mode: 2'd1, corrupt: 1'b0, exp_wr: 16, exp_rd: 0,  exp_err: 16'd0, exp_first: '0,     exp_pass: 1'b1};
    vecs[2] = '{mode: 2'd2, corrupt: 1'b0, exp_wr: 0,  exp_rd: 16, exp_err: 16'd0, exp_first: '0,     exp_pass: 1'b1};
    vecs[3] = '{mode: 2'd3, corrupt: 1'b0, exp_wr: 16, exp_rd: 16, exp_err: 16'd0, exp_first: '0,     exp_pass: 1'b1};
    vecs[4] = '{mode: 2'd0, corrupt: 1'b1, exp_wr: 16, exp_rd: 16, exp_err: 16'd2, exp_first: AW'(24), exp_pass: 1'b0};

    clear_model();
    for (int i = 0; i < 64; i++) mem[i] = '0;

    // Reset values.
    @(negedge clk);
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Start while calibration is low is ignored.
    start_run(2'd0);
    repeat (5) @(negedge clk);
    check("nocal_busy", busy, 1'b0);
    check("nocal_done", done, 1'b0);
    check("nocal_app_en_cycles", en_seen, 0);
    init_calib_complete = 1'b1;

    // Table-driven full runs.
    for (int v = 0; v < 5; v++) begin
      clear_model();
      corrupt = vecs[v].corrupt;
      start_run(vecs[v].mode);
      check($sformatf("v%0d_first_app_en", v), app_en, 1'b1);
      wait_done(500, n);
      check($sformatf("v%0d_pass", v), pass, vecs[v].exp_pass);
      check($sformatf("v%0d_timeout", v), timeout, 1'b0);
      check($sformatf("v%0d_busy", v), busy, 1'b0);
      check($sformatf("v%0d_err_count", v), err_count, vecs[v].exp_err);
      check($sformatf("v%0d_first_err_addr", v), first_err_addr, vecs[v].exp_first);
      check($sformatf("v%0d_writes", v), wdat_cnt, vecs[v].exp_wr);
      check($sformatf("v%0d_write_cmds", v), wcmd_cnt, vecs[v].exp_wr);
      check($sformatf("v%0d_read_cmds", v), rcmd_cnt, vecs[v].exp_rd);
      check($sformatf("v%0d_read_returns", v), rd_ret_cnt, vecs[v].exp_rd);
      check($sformatf("v%0d_model_errors", v), model_bad, 0);
      if (vecs[v].exp_rd > 0)
        check($sformatf("v%0d_done_after_last_valid", v), cyc - last_valid_cyc, 2);
    end
    corrupt = 1'b0;

    // Write-data stall on beat 5: command accepted at once, data held 4 cycles.
    clear_model();
    start_run(2'd0);
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      if (app_en && app_cmd == 3'b000 && app_addr == AW'(40)) found = 1'b1;
      else @(negedge clk);
    end
    check("stall_beat5_seen", found, 1'b1);
    held = app_wdf_data;
    check("stall_beat5_data", {63'd0, held == exp_data(5)}, 1);
    for (int j = 0; j < 4; j++) begin
      if (j > 0) @(negedge clk);
      check($sformatf("stall_c%0d_app_en", j), app_en, (j == 0) ? 1'b1 : 1'b0);
      check($sformatf("stall_c%0d_wren", j), app_wdf_wren, 1'b1);
      check($sformatf("stall_c%0d_data_held", j), {63'd0, app_wdf_data == held}, 1);
      if (j == 0) app_wdf_rdy = 1'b0;
      if (j == 3) app_wdf_rdy = 1'b1;
    end
    @(negedge clk);
    check("stall_next_app_en", app_en, 1'b1);
    check("stall_next_addr", app_addr, 48);
    wait_done(500, n);
    check("stall_pass", pass, 1'b1);
    check("stall_write_cmds", wcmd_cnt, 16);
    check("stall_writes", wdat_cnt, 16);
    check("stall_model_errors", model_bad, 0);

    // Read-only run with no data ever returned: watchdog aborts.
    clear_model();
    no_return = 1'b1;
    start_run(2'd2);
    wait_done(6000, n);
    check("wdog_cycles", n, TO);
    check("wdog_timeout", timeout, 1'b1);
    check("wdog_pass", pass, 1'b0);
    check("wdog_read_cmds", rcmd_cnt, 16);
    @(negedge clk);
    clear_model();
    no_return = 1'b0;

    // Reset in the middle of WRITE at beat 7, then a fresh run.
    start_run(2'd0);
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      if (app_en && app_cmd == 3'b000 && app_addr == AW'(56)) found = 1'b1;
      else @(negedge clk);
    end
    check("rstmid_beat7_seen", found, 1'b1);
    rst = 1'b1;
    #1;
    check_all_zero("rstmid");
    repeat (2) @(negedge clk);
    clear_model();
    rst = 1'b0;
    start_run(2'd0);
    check("rstmid_restart_app_en", app_en, 1'b1);
    check("rstmid_restart_addr", app_addr, 0);
    wait_done(500, n);
    check("rstmid_pass", pass, 1'b1);
    check("rstmid_writes", wdat_cnt, 16);
    check("rstmid_model_errors", model_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
